// File: rtl/axi_slice_if.sv
// -----------------------------------------------------------------------------
// axi_slice_if
// Single-channel AXI-style valid/ready handshake bundle.
//   valid : beat offered by the master side
//   ready : beat accepted by the slave side
//   data  : payload, DATA_WIDTH bits
// Modports:
//   master : drives valid/data, observes ready
//   slave  : observes valid/data, drives ready
// -----------------------------------------------------------------------------
interface axi_slice_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axi_slice_buffer.sv
// -----------------------------------------------------------------------------
// axi_slice_buffer
// One AXI channel buffer slice built on an internal circular buffer.
// MODE 0 = bypass wires, 1 = registered, 2 = fall-through.
// Ports:
//   clk_i         : clock, all state updates on rising edge
//   rst_i         : synchronous active-high reset
//   flush_i       : synchronous drop of all stored entries
//   i_up          : upstream handshake (slave side: valid/data in, ready out)
//   o_dn          : downstream handshake (master side: valid/data out, ready in)
//   count_o       : number of stored entries
//   almost_full_o : count_o >= THRESHOLD
// -----------------------------------------------------------------------------
module axi_slice_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 2,
   parameter int MODE       = 1,
   parameter int THRESHOLD  = DEPTH - 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   axi_slice_if.slave                 i_up,
   axi_slice_if.master                o_dn,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       almost_full_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DATA_WIDTH < 1 || DEPTH < 1 || MODE < 0 || MODE > 2 ||
       THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_bad_params
      $error("axi_slice_buffer: illegal parameter set");
   end

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_block;
   logic                  w_ready_up;
   logic                  w_thru;
   logic                  w_valid_dn;
   logic [DATA_WIDTH-1:0] w_data_dn;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_store;
   logic                  w_unstore;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(DEPTH));
   // Reset and flush both close the slice in the same cycle so nothing moves.
   assign w_block    = rst_i | flush_i;
   assign w_ready_up = ~w_block & ~w_full;
   // Fall-through: an empty buffer presents the incoming beat directly.
   assign w_thru     = (MODE == 2) && w_empty && i_up.valid;
   assign w_valid_dn = ~w_block & (~w_empty | w_thru);
   assign w_data_dn  = (MODE == 2 && w_empty) ? i_up.data : r_mem[r_rptr];

   assign w_push     = i_up.valid & w_ready_up;
   assign w_pop      = w_valid_dn & o_dn.ready;
   // A fall-through beat taken downstream in the same cycle is never stored,
   // and popping it does not consume a stored entry.
   assign w_store    = w_push & ~(w_thru & o_dn.ready);
   assign w_unstore  = w_pop & ~w_empty;

   assign i_up.ready    = (MODE == 0) ? o_dn.ready : w_ready_up;
   assign o_dn.valid    = (MODE == 0) ? i_up.valid : w_valid_dn;
   assign o_dn.data     = (MODE == 0) ? i_up.data  : w_data_dn;
   assign count_o       = (MODE == 0 || rst_i) ? '0 : r_count;
   assign almost_full_o = (MODE != 0) && !rst_i && (r_count >= CW'(THRESHOLD));

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_store)   r_wptr <= next_ptr(r_wptr);
         if (w_unstore) r_rptr <= next_ptr(r_rptr);
         r_count <= r_count + CW'(w_store) - CW'(w_unstore);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (w_store) r_mem[r_wptr] <= i_up.data;
   end

   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_unstore && w_empty));
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_store && w_full) && (r_count <= CW'(DEPTH)));
endmodule
